// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART bootloader command responder.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    HDR,
    WR_DATA,
    RD_REQ,
    RD_WAIT,
    RD_SEND
  } boot_state_e;

  typedef struct packed {
    logic        wr;
    logic [14:0] addr;
    logic [15:0] ndata;
  } boot_hdr_t;

  localparam int BOOT_WR_BIT = 31;

endpackage

// File: rtl/boot_byte_ser.sv
// Splits a 32-bit word into four bytes on a valid/ready port, LSB first;
// done pulses during the fourth handshake.
module boot_byte_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [31:0] word_reg;
  logic [1:0]  idx_reg;
  logic        active_reg;
  logic [7:0]  byte_lane [4];
  logic        handshake;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lane[gi] = word_reg[gi*8 +: 8];
  end

  assign tx_data   = byte_lane[idx_reg];
  assign tx_valid  = active_reg;
  assign handshake = active_reg && tx_ready;
  assign done      = handshake && (idx_reg == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg   <= '0;
      idx_reg    <= '0;
      active_reg <= 1'b0;
    end else if (load) begin
      word_reg   <= word;
      idx_reg    <= '0;
      active_reg <= 1'b1;
    end else if (handshake) begin
      idx_reg <= idx_reg + 2'd1;
      if (idx_reg == 2'd3) active_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_boot_cmd.sv
// Bootloader command responder: decodes UART headers, writes IMEM, streams DMEM back.
// Optional idle timeout on partial frames: define UART_BOOT_TIMEOUT_EN.
module uart_boot_cmd
  import uart_boot_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  dmem_req,
  input  logic                  dmem_gnt,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [31:0]           dmem_rdata,
  output logic                  busy
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("uart_boot_cmd: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 15) begin : g_bad_addr_width
    $error("uart_boot_cmd: ADDR_WIDTH must be 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_boot_cmd: TIMEOUT_CYCLES must be positive");
  end

  boot_state_e           state_reg, state_next;
  logic [31:0]           shift_reg, shift_next;
  logic [1:0]            byte_cnt_reg, byte_cnt_next;
  logic [15:0]           word_cnt_reg, word_cnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  we_reg, we_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic [31:0]           shift_in;
  boot_hdr_t             hdr;
  logic                  ser_load, ser_done;
  logic                  timeout_hit;
  logic                  unused_hdr;

  assign shift_in   = {rx_data, shift_reg[31:8]};
  assign hdr        = boot_hdr_t'(shift_in);
  assign unused_hdr = ^{hdr.wr, hdr.addr};

`ifdef UART_BOOT_TIMEOUT_EN
  logic [31:0] idle_cnt_reg;
  logic        idle_run;

  assign idle_run    = ((state_reg == HDR) && (byte_cnt_reg != 2'd0)) || (state_reg == WR_DATA);
  assign timeout_hit = idle_run && !rx_valid && !we_reg &&
                       (idle_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              idle_cnt_reg <= '0;
    else if (!idle_run || rx_valid || timeout_hit) idle_cnt_reg <= '0;
    else                                     idle_cnt_reg <= idle_cnt_reg + 32'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    byte_cnt_next = byte_cnt_reg;
    word_cnt_next = word_cnt_reg;
    addr_next     = addr_reg;
    we_next       = 1'b0;
    wdata_next    = wdata_reg;
    ser_load      = 1'b0;
    dmem_req      = 1'b0;

    case (state_reg)
      HDR: begin
        if (rx_valid) begin
          shift_next    = shift_in;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            addr_next     = hdr.addr[ADDR_WIDTH-1:0];
            word_cnt_next = hdr.ndata;
            if (hdr.ndata != 16'd0)
              state_next = shift_in[BOOT_WR_BIT] ? WR_DATA : RD_REQ;
          end
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          shift_next    = shift_in;
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            we_next    = 1'b1;
            wdata_next = shift_in;
          end
        end
        // Bookkeeping happens in the strobe cycle; a byte arriving then
        // after the last word is already the next header's first byte.
        if (we_reg) begin
          addr_next     = addr_reg + ADDR_WIDTH'(1);
          word_cnt_next = word_cnt_reg - 16'd1;
          if (word_cnt_reg == 16'd1) state_next = HDR;
        end
      end
      RD_REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        ser_load   = 1'b1;
        state_next = RD_SEND;
      end
      RD_SEND: begin
        if (ser_done) begin
          addr_next     = addr_reg + ADDR_WIDTH'(1);
          word_cnt_next = word_cnt_reg - 16'd1;
          state_next    = (word_cnt_reg == 16'd1) ? HDR : RD_REQ;
        end
      end
      default: state_next = HDR;
    endcase

    if (timeout_hit) begin
      state_next    = HDR;
      byte_cnt_next = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= HDR;
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
      word_cnt_reg <= '0;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      byte_cnt_reg <= byte_cnt_next;
      word_cnt_reg <= word_cnt_next;
      addr_reg     <= addr_next;
      we_reg       <= we_next;
      wdata_reg    <= wdata_next;
    end
  end

  boot_byte_ser u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ser_load),
    .word     (dmem_rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (ser_done)
  );

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign dmem_addr  = addr_reg;
  assign busy       = !((state_reg == HDR) && (byte_cnt_reg == 2'd0));

endmodule

// File: tb/tb_uart_boot_cmd.sv
// Scoreboard bench for uart_boot_cmd; the timeout case runs when UART_BOOT_TIMEOUT_EN is defined.
module tb_uart_boot_cmd;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          dmem_req;
  logic          dmem_gnt;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  uart_boot_cmd #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_req   (dmem_req),
    .dmem_gnt   (dmem_gnt),
    .dmem_addr  (dmem_addr),
    .dmem_rdata (dmem_rdata),
    .busy       (busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  int gnt_stall = 0;
  int rdy_stall = 0;
  int tx_seen = 0;

  logic [AW-1:0] exp_waddr [$];
  logic [31:0]   exp_wdata [$];
  logic [7:0]    exp_tx    [$];
  logic [31:0]   dmem      [2**AW];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_waddr.push_back(a);
    exp_wdata.push_back(d);
  endtask

  task automatic exp_word_tx(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_tx.push_back(w[b*8 +: 8]);
  endtask

  // Called and returning at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int b = 0; b < 4; b++) send_byte(w[b*8 +: 8], gap);
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (cyc < 3000 && !(exp_waddr.size() == 0 && exp_tx.size() == 0 && !busy)) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_complete"}, 32'(cyc < 3000), 32'd1);
    $display("transaction %s finished after %0d cycles", name, cyc);
  endtask

  // DMEM model and grant driver, updated just after each rising edge.
  initial begin
    logic          pend;
    logic [AW-1:0] pa;
    pend       = 1'b0;
    pa         = '0;
    dmem_gnt   = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (pend) dmem_rdata = dmem[pa];
      dmem_gnt = dmem_req && (gnt_stall == 0);
      if (dmem_req && gnt_stall > 0) gnt_stall--;
      pend = dmem_req && dmem_gnt;
      pa   = dmem_addr;
    end
  end

  // Transmitter: optionally stalls before the third byte of a word.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tx_valid && rdy_stall > 0 && (tx_seen % 4) == 2) begin
        tx_ready = 1'b0;
        rdy_stall--;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Monitor: samples at the falling edge, pops the scoreboard on each output event.
  initial begin
    logic          pv, pr, preq, pg;
    logic [7:0]    pd;
    logic [AW-1:0] pa;
    pv = 0; pr = 0; preq = 0; pg = 0; pd = '0; pa = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; preq = 0;
      end else begin
        if (imem_we) begin
          $display("imem write addr=%h data=%h", imem_addr, imem_wdata);
          if (exp_waddr.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL imem_unexpected: got write addr=%h data=%h, expected no write", imem_addr, imem_wdata);
          end else begin
            check("imem_addr", 32'(imem_addr), 32'(exp_waddr.pop_front()));
            check("imem_wdata", imem_wdata, exp_wdata.pop_front());
          end
        end
        if (pv && !pr) begin
          check("tx_valid_hold", 32'(tx_valid), 32'd1);
          check("tx_data_hold", 32'(tx_data), 32'(pd));
        end
        if (preq && !pg) begin
          check("dmem_req_hold", 32'(dmem_req), 32'd1);
          check("dmem_addr_hold", 32'(dmem_addr), 32'(pa));
        end
        if (tx_valid && tx_ready) begin
          $display("tx byte %h", tx_data);
          tx_seen++;
          if (exp_tx.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL tx_unexpected: got byte %h, expected no byte", tx_data);
          end else begin
            check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
          end
        end
        pv = tx_valid; pr = tx_ready; pd = tx_data;
        preq = dmem_req; pg = dmem_gnt; pa = dmem_addr;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    for (int i = 0; i < 2**AW; i++) dmem[i] = '0;
    dmem[5] = 32'hDEADBEEF;
    dmem[6] = 32'hBAD00001;

    repeat (3) @(posedge clk); #1;
    check("rst_imem_we",    32'(imem_we),    32'd0);
    check("rst_imem_addr",  32'(imem_addr),  32'd0);
    check("rst_imem_wdata", imem_wdata,      32'd0);
    check("rst_tx_valid",   32'(tx_valid),   32'd0);
    check("rst_tx_data",    32'(tx_data),    32'd0);
    check("rst_dmem_req",   32'(dmem_req),   32'd0);
    check("rst_dmem_addr",  32'(dmem_addr),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-word write at 0..2.
    exp_write(11'h000, 32'h11111111);
    exp_write(11'h001, 32'h22222222);
    exp_write(11'h002, 32'h33333333);
    send_word(32'h80000003, 2);
    check("busy_in_write", 32'(busy), 32'd1);
    send_word(32'h11111111, 2);
    send_word(32'h22222222, 2);
    send_word(32'h33333333, 2);
    wait_done("write3");
    check("busy_after_write3", 32'(busy), 32'd0);

    // Two-word read from 5.
    exp_word_tx(32'hDEADBEEF);
    exp_word_tx(32'hBAD00001);
    send_word(32'h00050002, 2);
    wait_done("read2");

    // Same read with grant and ready stalls.
    gnt_stall = 10;
    rdy_stall = 7;
    exp_word_tx(32'hDEADBEEF);
    exp_word_tx(32'hBAD00001);
    send_word(32'h00050002, 2);
    wait_done("read2_stall");
    check("gnt_stall_consumed", 32'(gnt_stall), 32'd0);
    check("rdy_stall_consumed", 32'(rdy_stall), 32'd0);

    // Address wrap from 0x7FF.
    exp_write(11'h7FF, 32'hCAFEF00D);
    exp_write(11'h000, 32'h12345678);
    send_word(32'h87FF0002, 2);
    send_word(32'hCAFEF00D, 2);
    send_word(32'h12345678, 2);
    wait_done("wrap");

    // Upper header address bits ignored (0x7803 -> 0x003).
    exp_write(11'h003, 32'h0F0F0F0F);
    send_word(32'hF8030001, 1);
    send_word(32'h0F0F0F0F, 1);
    wait_done("addr_mask");

    // ndata == 0: nothing happens, busy drops immediately.
    send_word(32'h00000000, 0);
    check("busy_ndata0", 32'(busy), 32'd0);
    repeat (20) begin @(posedge clk); #1; end
    check("tx_idle_ndata0", 32'(tx_valid), 32'd0);

    // Back-to-back write frames with no idle gaps.
    exp_write(11'h010, 32'hA1A2A3A4);
    exp_write(11'h020, 32'hB1B2B3B4);
    send_word(32'h80100001, 0);
    send_word(32'hA1A2A3A4, 0);
    send_word(32'h80200001, 0);
    send_word(32'hB1B2B3B4, 0);
    wait_done("back_to_back");

    // Reset after two data bytes: the partial word must never be written.
    send_word(32'h80000001, 2);
    send_byte(8'h77, 2);
    send_byte(8'h66, 2);
    rst_n = 1'b0;
    #1;
    check("busy_in_reset", 32'(busy), 32'd0);
    check("imem_we_in_reset", 32'(imem_we), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_write(11'h000, 32'hA5A55A5A);
    send_word(32'h80000001, 2);
    send_word(32'hA5A55A5A, 2);
    wait_done("after_reset");

`ifdef UART_BOOT_TIMEOUT_EN
    // Two stale header bytes must be discarded by the idle timeout.
    send_byte(8'h01, 2);
    send_byte(8'h00, 2);
    check("busy_partial_hdr", 32'(busy), 32'd1);
    repeat (150) begin @(posedge clk); #1; end
    check("busy_after_timeout", 32'(busy), 32'd0);
    exp_write(11'h040, 32'h5555AAAA);
    send_word(32'h80400001, 2);
    send_word(32'h5555AAAA, 2);
    wait_done("timeout");
`endif

    repeat (5) begin @(posedge clk); #1; end
    check("exp_writes_left", 32'(exp_waddr.size()), 32'd0);
    check("exp_tx_left", 32'(exp_tx.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
